// File: rtl/mio_bus_interface_if.sv
// Signal bundle between the CPU control/datapath, the bridge and the RAM/IO buses.
// The bridge takes the slave modport; the CPU side and the memories take the master modport.
interface mio_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        MIO_ready;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        ram_sel;
  logic        io_sel;
  logic [31:0] ram_rdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic [1:0]  err;

  modport slave (
    input  MemRead, MemWrite, addr, wdata, ram_rdata, io_rdata, io_ack,
    output rdata, MIO_ready, bus_addr, bus_wdata, bus_we, ram_sel, io_sel, err
  );

  modport master (
    output MemRead, MemWrite, addr, wdata, ram_rdata, io_rdata, io_ack,
    input  rdata, MIO_ready, bus_addr, bus_wdata, bus_we, ram_sel, io_sel, err
  );
endinterface

// File: rtl/mio_bus_interface.sv
// Memory/IO bridge: runs one RAM or IO access per MemRead/MemWrite request,
// registers read data as the MDR and pulses MIO_ready for one cycle on completion.
//
// state   | meaning
// IDLE    | waiting for MemRead/MemWrite; latches address, data and direction
// RAM_ACC | RAM access in progress, exactly RAM_WAIT cycles
// IO_ACC  | IO access in progress, waits for io_ack or the timeout
// DONE    | MIO_ready high for one cycle; requests ignored
module mio_bus_interface #(
  parameter int         RAM_WAIT   = 2,
  parameter int         IO_TIMEOUT = 16,
  parameter logic [3:0] IO_NIBBLE  = 4'hF
) (
  input  logic    clk,
  input  logic    reset,
  mio_bus_if.slave mio
);

  localparam int CW = (RAM_WAIT   > 1) ? $clog2(RAM_WAIT)   : 1;
  localparam int TW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          req;
  logic          is_io;
  logic          io_to;

  assign req   = mio.MemRead | mio.MemWrite;
  assign is_io = (mio.addr[31:28] == IO_NIBBLE);
  assign io_to = (tcnt == TW'(IO_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = is_io ? IO_ACC : RAM_ACC;
      RAM_ACC: if (cnt == '0) state_nxt = DONE;
      IO_ACC:  if (mio.io_ack || io_to) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mio.MIO_ready = (state == DONE);
  assign mio.ram_sel   = (state == RAM_ACC);
  assign mio.io_sel    = (state == IO_ACC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mio.rdata     <= '0;
      mio.err       <= '0;
      mio.bus_addr  <= '0;
      mio.bus_wdata <= '0;
      mio.bus_we    <= 1'b0;
      cnt           <= '0;
      tcnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous read+write is run as a write and flagged.
            mio.bus_addr  <= mio.addr[31:2];
            mio.bus_wdata <= mio.wdata;
            mio.bus_we    <= mio.MemWrite;
            cnt           <= CW'(RAM_WAIT - 1);
            tcnt          <= '0;
            if (mio.addr[1:0] != 2'b00)     mio.err[0] <= 1'b1;
            if (mio.MemRead && mio.MemWrite) mio.err[1] <= 1'b1;
          end
        end
        RAM_ACC: begin
          if (cnt != '0)        cnt       <= cnt - 1'b1;
          else if (!mio.bus_we) mio.rdata <= mio.ram_rdata;
        end
        IO_ACC: begin
          if (mio.io_ack) begin
            if (!mio.bus_we) mio.rdata <= mio.io_rdata;
          end else if (io_to) begin
            if (!mio.bus_we) mio.rdata <= '0;
            mio.err[1] <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_interface.sv
// Bench for mio_bus_interface: directed and random accesses, expected
// completions queued by the driver and checked by an independent monitor.
module tb_mio_bus_interface;
  localparam int RAM_WAIT   = 2;
  localparam int IO_TIMEOUT = 16;
  localparam int BUDGET     = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mio_bus_if mio ();

  mio_bus_interface #(
    .RAM_WAIT  (RAM_WAIT),
    .IO_TIMEOUT(IO_TIMEOUT),
    .IO_NIBBLE (4'hF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mio  (mio)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  err;
    int          rdy;
    int          nram;
    int          nio;
  } exp_t;

  exp_t        sbq[$];
  exp_t        em;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ram_seen = 0;
  int          io_seen  = 0;
  logic [31:0] m_rdata;
  logic [1:0]  m_err;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts bus-select cycles and checks each completion against the queue
  always @(negedge clk) begin
    if (reset) begin
      ram_seen = 0;
      io_seen  = 0;
    end else begin
      if (mio.ram_sel && mio.io_sel) chk("sel_exclusive", 32'(mio.ram_sel & mio.io_sel), 32'd0);
      ram_seen += int'(mio.ram_sel);
      io_seen  += int'(mio.io_sel);
      if (mio.MIO_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got MIO_ready=1 expected 0 (t=%0t)", $time);
        end else begin
          em = sbq.pop_front();
          chk("rdata",      mio.rdata,           em.rdata);
          chk("bus_addr",   32'(mio.bus_addr),   em.baddr);
          chk("bus_we",     32'(mio.bus_we),     32'(em.we));
          chk("bus_wdata",  mio.bus_wdata,       em.wdata);
          chk("err",        32'(mio.err),        32'(em.err));
          chk("latency",    cyc,                 em.rdy);
          chk("ram_cycles", ram_seen,            em.nram);
          chk("io_cycles",  io_seen,             em.nio);
        end
        ram_seen = 0;
        io_seen  = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    mio.MemRead  = 1'b0;
    mio.MemWrite = 1'b0;
    mio.io_ack   = 1'b0;
    sbq.delete();
    m_rdata = '0;
    m_err   = '0;
    @(negedge clk);
    chk("rst_rdata",     mio.rdata,              32'd0);
    chk("rst_err",       32'(mio.err),           32'd0);
    chk("rst_ready",     32'(mio.MIO_ready),     32'd0);
    chk("rst_sel",       32'({mio.ram_sel, mio.io_sel}), 32'd0);
    chk("rst_bus_we",    32'(mio.bus_we),        32'd0);
    chk("rst_bus_addr",  32'(mio.bus_addr),      32'd0);
    chk("rst_bus_wdata", mio.bus_wdata,          32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One access; k is the IO_ACC cycle on which io_ack is given, 0 = never.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int k, input logic [31:0] iodat, input bit hold);
    exp_t e;
    int   lat;
    int   j;
    bit   seen;
    bit   io;
    bit   acked;
    io    = (a[31:28] == 4'hF);
    acked = (k >= 1) && (k <= IO_TIMEOUT);
    @(negedge clk);
    mio.MemRead  = rd;
    mio.MemWrite = wr;
    mio.addr     = a;
    mio.wdata    = wd;
    mio.io_ack   = 1'b0;
    @(posedge clk);
    #1;
    if (a[1:0] != 2'b00) m_err[0] = 1'b1;
    if (rd && wr)        m_err[1] = 1'b1;
    e.nram = 0;
    e.nio  = 0;
    if (io) begin
      lat   = acked ? k + 1 : IO_TIMEOUT + 1;
      e.nio = lat - 1;
      if (!acked) m_err[1] = 1'b1;
      if (!wr)    m_rdata = acked ? iodat : 32'd0;
    end else begin
      lat    = RAM_WAIT + 1;
      e.nram = RAM_WAIT;
      if (!wr) m_rdata = rdat;
    end
    e.rdata = m_rdata;
    e.baddr = {2'b00, a[31:2]};
    e.we    = wr;
    e.wdata = wd;
    e.err   = m_err;
    e.rdy   = cyc + lat - 1;
    sbq.push_back(e);
    j    = 1;
    seen = 1'b0;
    while (!seen && j <= BUDGET) begin
      // Data buses carry noise except on the cycle where they are defined valid
      mio.ram_rdata = (!io && j == RAM_WAIT) ? rdat : $urandom;
      mio.io_ack    = io && (j == k);
      mio.io_rdata  = (io && j == k) ? iodat : $urandom;
      @(negedge clk);
      if (mio.MIO_ready) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        j++;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no MIO_ready within %0d cycles expected latency %0d", BUDGET, lat);
      sbq.delete();
    end
    if (!hold) begin
      mio.MemRead  = 1'b0;
      mio.MemWrite = 1'b0;
    end
    @(posedge clk);
    #1;
    mio.MemRead  = 1'b0;
    mio.MemWrite = 1'b0;
    mio.io_ack   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    bit          rd, wr;
    int          k;
    mio.MemRead   = 1'b0;
    mio.MemWrite  = 1'b0;
    mio.addr      = '0;
    mio.wdata     = '0;
    mio.ram_rdata = '0;
    mio.io_rdata  = '0;
    mio.io_ack    = 1'b0;
    reset         = 1'b1;
    #12;
    do_reset();

    do_txn(1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h0,  1);
    do_txn(0, 1, 32'h0000_0020, 32'h1234_5678, 32'h5555_AAAA, 0, 32'h0,  1);
    do_txn(1, 0, 32'hF000_0008, 32'h0,         32'h0,         3, 32'hA5, 0);

    // Reset in the middle of a RAM access
    @(negedge clk);
    mio.MemRead = 1'b1;
    mio.addr    = 32'h0000_0040;
    @(posedge clk);
    #3;
    reset       = 1'b1;
    mio.MemRead = 1'b0;
    m_rdata     = '0;
    m_err       = '0;
    @(negedge clk);
    chk("midrst_ram_sel", 32'(mio.ram_sel),   32'd0);
    chk("midrst_rdata",   mio.rdata,          32'd0);
    chk("midrst_ready",   32'(mio.MIO_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_idle", 32'({mio.MIO_ready, mio.ram_sel, mio.io_sel}), 32'd0);
    end
    @(posedge clk);
    #1;

    do_txn(1, 0, 32'hF000_0100, 32'h0,         32'h0,         0, 32'h0,  0);
    do_txn(1, 1, 32'h0000_0006, 32'hCAFE_F00D, 32'h7777_7777, 0, 32'h0,  1);

    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 2) == 0) a = {4'hF, 28'($urandom)};
        else                           a = {4'($urandom_range(0, 14)), 28'($urandom)};
        if (b < 2 || $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        rd = $urandom_range(0, 1) == 1;
        wr = !rd;
        if (b >= 2 && $urandom_range(0, 7) == 0) begin
          rd = 1'b1;
          wr = 1'b1;
        end
        k = (b == 0) ? $urandom_range(1, IO_TIMEOUT) : $urandom_range(0, IO_TIMEOUT);
        do_txn(rd, wr, a, $urandom, $urandom, k, $urandom, $urandom_range(0, 1) == 1);
      end
    end

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d pending completions expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
